pid_controller: RTL and testbench

- Discrete-time PID controller for the motor-control loop: one signed 16-bit error sample per clock in, one saturated signed 16-bit control effort per clock out.
- Fixed-point gains are set by parameters and scaled by 2^FRAC.
- Integrator is clamped for anti-windup; output is registered with a fixed 2-cycle latency.

---
 rtl/pid_controller_if.sv | 17 +
 rtl/pid_controller.sv | 95 +++++++++
 tb/tb_pid_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/pid_controller_if.sv
// ---------------------------------------------------------------------------
// pid_controller_if
// Sample/effort bus between the motor-control loop and the PID controller.
// A new error sample is presented on every clock, so there is no handshake.
//   e_in  : signed 16-bit error sample (driven by the master)
//   u_out : signed 16-bit saturated control effort (driven by the controller)
// Modports:
//   master : the loop side (drives e_in, observes u_out)
//   slave  : the controller side (observes e_in, drives u_out)
// ---------------------------------------------------------------------------
interface pid_controller_if;
    logic signed [15:0] e_in;
    logic signed [15:0] u_out;

    modport master (output e_in, input  u_out);
    modport slave  (input  e_in, output u_out);
endinterface

// File: rtl/pid_controller.sv
// ---------------------------------------------------------------------------
// pid_controller
// Two-stage pipelined discrete-time PID controller.
//   Stage 1 : clamps the integrator, forms the first difference and
//             registers the sample.
//   Stage 2 : forms KP*e + KI*integ + KD*deriv at full precision, floors it
//             by 2^FRAC and saturates it to 16 bits into the output register.
// A sample taken at edge k shows up on u_out after edge k+1.
// Ports:
//   clk   : system clock, all state updates on the rising edge
//   reset : synchronous active-low reset (0 clears all state)
//   bus   : slave side of pid_controller_if (e_in in, u_out out)
// ---------------------------------------------------------------------------
module pid_controller #(
    parameter logic signed [15:0] KP    = 16'sd256,
    parameter logic signed [15:0] KI    = 16'sd16,
    parameter logic signed [15:0] KD    = 16'sd0,
    parameter int                 FRAC  = 8,
    parameter logic signed [31:0] I_LIM = 32'sd1048576
) (
    input  logic              clk,
    input  logic              reset,
    pid_controller_if.slave   bus
);

    // Clamp bounds at 33 bits so integ + e can be compared before narrowing.
    localparam logic signed [32:0] I_HI = 33'(I_LIM);
    localparam logic signed [32:0] I_LO = -I_HI;

    // Gains sign-extended to the accumulator width.
    localparam logic signed [49:0] KP_X = 50'(KP);
    localparam logic signed [49:0] KI_X = 50'(KI);
    localparam logic signed [49:0] KD_X = 50'(KD);

    localparam logic signed [49:0] U_MAX = 50'sd32767;
    localparam logic signed [49:0] U_MIN = -50'sd32768;

    // Stage-1 registers. e_q doubles as e[n-1] for the next difference.
    logic signed [15:0] e_q;
    logic signed [31:0] integ_q;
    logic signed [16:0] deriv_q;
    logic signed [15:0] u_q;

    // Stage-1 next-state values
    logic signed [32:0] integ_sum;
    logic signed [31:0] integ_d;
    logic signed [16:0] deriv_d;

    // Stage-2 datapath
    logic signed [49:0] sum_d;
    logic signed [49:0] shifted_d;
    logic signed [15:0] u_d;

    always_comb begin
        integ_sum = 33'(integ_q) + 33'(bus.e_in);
        integ_d   = integ_sum[31:0];
        if (integ_sum > I_HI) begin
            integ_d = I_HI[31:0];
        end else if (integ_sum < I_LO) begin
            integ_d = I_LO[31:0];
        end

        // 17 bits holds the full [-65535, +65535] range of the difference.
        deriv_d = 17'(bus.e_in) - 17'(e_q);
    end

    always_comb begin
        // Every product fits in 50 bits, so nothing is lost before the shift.
        sum_d     = KP_X * 50'(e_q) + KI_X * 50'(integ_q) + KD_X * 50'(deriv_q);
        shifted_d = sum_d >>> FRAC;   // arithmetic shift: floor division
        u_d       = shifted_d[15:0];
        if (shifted_d > U_MAX) begin
            u_d = 16'sh7FFF;
        end else if (shifted_d < U_MIN) begin
            u_d = 16'sh8000;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q     <= '0;
            integ_q <= '0;
            deriv_q <= '0;
            u_q     <= '0;
        end else begin
            e_q     <= bus.e_in;
            integ_q <= integ_d;
            deriv_q <= deriv_d;
            u_q     <= u_d;
        end
    end

    assign bus.u_out = u_q;

endmodule

// File: tb/tb_pid_controller.sv
// ---------------------------------------------------------------------------
// tb_pid_controller
// Directed bench for pid_controller. Three instances share clk/reset:
//   u_def : default gains (step, reset, saturation, mid-run reset)
//   u_int : KP=0 KI=1 KD=0 (integrator clamp and unwind)
//   u_der : KP=0 KI=0 KD=256 (first difference and its extremes)
// Inputs change 1 time unit after each rising edge; u_out is sampled there.
// ---------------------------------------------------------------------------
module tb_pid_controller;

    logic clk = 1'b0;
    logic reset;

    pid_controller_if if_def ();
    pid_controller_if if_int ();
    pid_controller_if if_der ();

    pid_controller u_def (
        .clk   (clk),
        .reset (reset),
        .bus   (if_def.slave)
    );

    pid_controller #(
        .KP   (16'sd0),
        .KI   (16'sd1),
        .KD   (16'sd0),
        .FRAC (8)
    ) u_int (
        .clk   (clk),
        .reset (reset),
        .bus   (if_int.slave)
    );

    pid_controller #(
        .KP   (16'sd0),
        .KI   (16'sd0),
        .KD   (16'sd256),
        .FRAC (8)
    ) u_der (
        .clk   (clk),
        .reset (reset),
        .bus   (if_der.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               rst_n;
        logic signed [15:0] e;
        logic signed [15:0] u_exp;
    } vec_t;

    vec_t tbl[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx,
                         input logic signed [15:0] got,
                         input logic signed [15:0] exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_miss++;
            $display("FAIL %s[%0d]: u_out=%0d expected %0d", name, idx, got, exp_v);
        end else begin
            $display("ok   %s[%0d]: u_out=%0d", name, idx, got);
        end
    endtask

    task automatic add(input logic r, input int e, input int u);
        vec_t v;
        v.rst_n = r;
        v.e     = 16'(e);
        v.u_exp = 16'(u);
        tbl.push_back(v);
    endtask

    // Expected u_out values for the derivative instance, one edge after each sample.
    int der_e[9] = '{0, 50, 50, -30, -30, 32767, -32768, 32767, 0};
    int der_u[8] = '{0, 50, 0, -80, 0, 32767, -32768, 32767};

    initial begin
        int step_u[10] = '{0, 106, 112, 118, 125, 131, 137, 143, 150, 156};
        longint acc;
        int     exp_i;

        reset       = 1'b0;
        if_def.e_in = '0;
        if_int.e_in = '0;
        if_der.e_in = '0;

        // ---- table: reset, release, step, mid-run reset, restart ----
        for (int i = 0; i < 3; i++)  add(1'b0, 1000, 0);
        for (int i = 0; i < 3; i++)  add(1'b1, 0, 0);
        for (int i = 0; i < 10; i++) add(1'b1, 100, step_u[i]);
        add(1'b0, 100, 0);
        for (int i = 0; i < 4; i++)  add(1'b1, 100, step_u[i]);

        foreach (tbl[i]) begin
            reset       = tbl[i].rst_n;
            if_def.e_in = tbl[i].e;
            tick();
            check("table", i, if_def.u_out, tbl[i].u_exp);
        end

        // ---- output saturation with default gains ----
        reset = 1'b0;
        tick();
        reset       = 1'b1;
        if_def.e_in = 16'sd32767;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("sat_pos", k, if_def.u_out, (k == 0) ? 16'sd0 : 16'sd32767);
        end
        // Integrator sits at +1048576; each -32768 sample removes 32768,
        // so after t samples u = 32768 - 2048*t until it pins at -32768.
        if_def.e_in = -16'sd32768;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (t == 0) begin
                exp_i = 32767;
            end else begin
                exp_i = 32768 - 2048 * t;
                if (exp_i < -32768) exp_i = -32768;
            end
            check("sat_neg", t, if_def.u_out, 16'(exp_i));
        end

        // ---- integrator clamp, KI=1 ----
        reset = 1'b0;
        tick();
        reset       = 1'b1;
        if_int.e_in = 16'sd32767;
        for (int k = 0; k < 40; k++) begin
            tick();
            acc = 64'(32767) * k;
            if (acc > 1048576) acc = 1048576;
            if (k == 0 || k == 32 || k == 33 || k == 39)
                check("clamp", k, if_int.u_out, 16'(acc >>> 8));
        end
        if_int.e_in = -16'sd32767;
        tick();
        check("unwind", 0, if_int.u_out, 16'sd4096);
        if_int.e_in = 16'sd0;
        tick();
        check("unwind", 1, if_int.u_out, 16'sd3968);

        // ---- derivative, KD=256 ----
        reset = 1'b0;
        tick();
        reset = 1'b1;
        if_der.e_in = 16'(der_e[0]);
        tick();
        for (int i = 0; i < 8; i++) begin
            if_der.e_in = 16'(der_e[i + 1]);
            tick();
            check("deriv", i, if_der.u_out, 16'(der_u[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
